// File: rtl/dmem_pkg.sv
// +----------------------------------------------------------------------+
// | dmem_pkg : shared size encodings, FSM states and defaults for the    |
// |            paged data memory.                         Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam logic [1:0]  DMEM_SIZE_BYTE  = 2'b00;
  localparam logic [1:0]  DMEM_SIZE_HALF  = 2'b01;
  localparam logic [1:0]  DMEM_SIZE_WORD  = 2'b10;
  localparam logic [1:0]  DMEM_SIZE_DWORD = 2'b11;

  localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h1001_0000;

  typedef enum logic [0:0] {
    DMEM_IDLE = 1'b0,
    DMEM_HOLD = 1'b1
  } dmem_state_e;

  // A doubleword request on a 32-bit build degrades to a word access.
  function automatic logic [1:0] dmem_size_clamp(input logic [1:0] size, input int data_width);
    return (data_width == 32 && size == DMEM_SIZE_DWORD) ? DMEM_SIZE_WORD : size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_load_align.sv
// +----------------------------------------------------------------------+
// | dmem_load_align : shifts the addressed lanes to bit 0 and sign/zero  |
// |                   extends them.                      Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]           word,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] byte_off,
  input  logic [1:0]                      size,
  input  logic                            is_signed,
  output logic [DATA_WIDTH-1:0]           data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic                  sign_bit;

  always_comb begin
    shifted  = word >> {byte_off, 3'b000};
    mask     = '1;
    sign_bit = shifted[DATA_WIDTH-1];
    case (dmem_size_clamp(size, DATA_WIDTH))
      DMEM_SIZE_BYTE: begin
        mask     = DATA_WIDTH'(8'hFF);
        sign_bit = shifted[7];
      end
      DMEM_SIZE_HALF: begin
        mask     = DATA_WIDTH'(16'hFFFF);
        sign_bit = shifted[15];
      end
      DMEM_SIZE_WORD: begin
        mask     = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: ;
    endcase
    data = (shifted & mask) | ((is_signed && sign_bit) ? ~mask : '0);
  end

endmodule

`default_nettype wire

// File: rtl/paged_data_memory.sv
// +----------------------------------------------------------------------+
// | paged_data_memory : valid/ready data RAM with byte-lane stores and   |
// |   aligned, extended loads. Optional macro: DMEM_FAULT_EN.          |
// |                                                      Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module paged_data_memory
  import dmem_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  dmem_state_e           state;
  logic                  accept;
  logic                  fault;
  logic [31:0]           offset;
  logic [IDX_W-1:0]      index;
  logic [OFF_W-1:0]      raw_off;
  logic [OFF_W-1:0]      byte_off;
  logic [OFF_W-1:0]      lo_mask;
  logic [1:0]            size_eff;
  logic [NBYTES-1:0]     lane_mask;
  logic [NBYTES-1:0]     wmask;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_ready = reset_n && (state == DMEM_IDLE || resp_ready);
  assign accept    = req_valid && req_ready;

  // Index is taken modulo DEPTH_WORDS by truncation.
  assign offset   = req_addr - BASE_ADDR;
  assign index    = IDX_W'(offset >> OFF_W);
  assign raw_off  = OFF_W'(offset);
  assign size_eff = dmem_size_clamp(req_size, DATA_WIDTH);

  always_comb begin
    lo_mask   = '1;
    lane_mask = '1;
    case (size_eff)
      DMEM_SIZE_BYTE: begin
        lo_mask   = '0;
        lane_mask = NBYTES'(1'b1);
      end
      DMEM_SIZE_HALF: begin
        lo_mask   = OFF_W'(1);
        lane_mask = NBYTES'(2'b11);
      end
      DMEM_SIZE_WORD: begin
        lo_mask   = OFF_W'(3);
        lane_mask = NBYTES'(4'hF);
      end
      default: ;
    endcase
  end

`ifdef DMEM_FAULT_EN
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'(NBYTES);
  // An address below BASE_ADDR wraps to a huge offset and lands here too.
  assign fault    = ((raw_off & lo_mask) != '0) || ({1'b0, offset} >= MEM_BYTES);
  assign byte_off = raw_off;
`else
  assign fault    = 1'b0;
  assign byte_off = raw_off & ~lo_mask;
`endif

  assign wmask    = lane_mask << byte_off;
  assign wdata_sh = req_wdata << {byte_off, 3'b000};
  assign rd_word  = mem[index];

  always_ff @(posedge clock) begin
    if (accept && req_write && !fault) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wmask[i]) mem[index][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  dmem_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .word      (rd_word),
    .byte_off  (byte_off),
    .size      (size_eff),
    .is_signed (req_signed),
    .data      (load_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= DMEM_IDLE;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (accept) state <= DMEM_HOLD;
        end
        DMEM_HOLD: begin
          if (!accept && resp_ready) begin
            state      <= DMEM_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= DMEM_IDLE;
      endcase
      if (accept) begin
        resp_valid <= 1'b1;
        resp_write <= req_write;
        resp_rdata <= (req_write || fault) ? '0 : load_data;
        resp_fault <= fault;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_paged_data_memory.sv
// +----------------------------------------------------------------------+
// | tb_paged_data_memory : scoreboard bench with a byte-array model of   |
// |   the memory. Honours DMEM_FAULT_EN.                 Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_paged_data_memory;

  localparam logic [31:0] BASE      = 32'h1001_0000;
  localparam int          MEM_BYTES = 2048 * 4;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_write  = 1'b0;
  logic [1:0]  req_size   = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr   = 32'd0;
  logic [31:0] req_wdata  = 32'd0;
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_write;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic        flt;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mb [MEM_BYTES];
  int          checks  = 0;
  int          passed  = 0;
  int          bp_mode = 0;   // 0 always ready, 1 random, 2 stalled
  int unsigned cyc     = 0;

  paged_data_memory dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    case (bp_mode)
      0:       resp_ready = 1'b1;
      2:       resp_ready = 1'b0;
      default: resp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
  endtask

  // Reference: memory as a flat little-endian byte array indexed by offset.
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic flt);
    int unsigned n;
    logic [31:0] off;
    logic [63:0] v;
    n   = (sz == 2'd3) ? 4 : (1 << sz);
    off = addr - BASE;
    rd  = '0;
    flt = 1'b0;
`ifdef DMEM_FAULT_EN
    if (off >= MEM_BYTES || (off % n) != 0) begin
      flt = 1'b1;
      return;
    end
`else
    off = (off - (off % n)) % MEM_BYTES;
`endif
    if (wr) begin
      for (int k = 0; k < n; k++) mb[off + k] = 8'(wd >> (8 * k));
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v = v | (64'(mb[off + k]) << (8 * k));
      if (sg && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      rd = v[31:0];
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input string tag,
                       input bit use_exp = 1'b0, input logic [31:0] erd = 32'd0,
                       input logic eflt = 1'b0);
    exp_t        e;
    logic [31:0] mrd;
    logic        mflt;
    int          n;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) begin
      checks++;
      $display("FAIL %s_accept: req_ready stayed 0 for %0d cycles, want 1", tag, n);
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      return;
    end
    @(posedge clock);
    model(wr, sz, sg, addr, wd, mrd, mflt);
    e.wr  = wr;
    e.rd  = use_exp ? erd : mrd;
    e.flt = use_exp ? eflt : mflt;
    e.tag = tag;
    sbq.push_back(e);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    req_valid = 1'b0;
    bp_mode   = 0;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL %s_drain: %0d responses outstanding, want 0", tag, sbq.size());
      sbq.delete();
    end
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (sbq.size() == 0) begin
        if (resp_valid) chk("spurious_resp_valid", 32'(resp_valid), 32'd0);
      end else if (!resp_valid) begin
        chk({sbq[0].tag, "_valid"}, 32'(resp_valid), 32'd1);
      end else begin
        chk({sbq[0].tag, "_write"}, 32'(resp_write), 32'(sbq[0].wr));
        chk({sbq[0].tag, "_rdata"}, resp_rdata, sbq[0].rd);
        chk({sbq[0].tag, "_fault"}, 32'(resp_fault), 32'(sbq[0].flt));
        if (resp_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int unsigned t0;
    req_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_write", 32'(resp_write), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    issue(1'b1, 2'd2, 1'b0, BASE, 32'hDEAD_BEEF, "sw_deadbeef", 1'b1, 32'd0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, BASE, 32'd0, "lw_deadbeef", 1'b1, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 2'd0, 1'b0, BASE + 3, 32'h0000_0080, "sb_80", 1'b1, 32'd0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, BASE + 3, 32'd0, "lb_signed", 1'b1, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 2'd0, 1'b0, BASE + 3, 32'd0, "lbu", 1'b1, 32'h0000_0080, 1'b0);
    issue(1'b0, 2'd1, 1'b1, BASE + 2, 32'd0, "lh_signed", 1'b1, 32'hFFFF_80AD, 1'b0);
`ifdef DMEM_FAULT_EN
    issue(1'b0, 2'd1, 1'b1, BASE + 1, 32'd0, "lh_misaligned", 1'b1, 32'd0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'h1234_5678, "sw_below_base", 1'b1, 32'd0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, BASE, 32'd0, "lw_after_fault", 1'b1, 32'h80AD_BEEF, 1'b0);
`else
    issue(1'b0, 2'd1, 1'b1, BASE + 1, 32'd0, "lh_rounded", 1'b1, 32'hFFFF_BEEF, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'h1234_5678, "sw_wrap");
    issue(1'b0, 2'd2, 1'b0, BASE, 32'd0, "lw_after_wrap", 1'b1, 32'h1234_5678, 1'b0);
`endif

    for (int i = 1; i < 64; i++) issue(1'b1, 2'd2, 1'b0, BASE + 32'(i * 4), $urandom, "fill");
    drain("fill");

    // Stall: a second request must wait while the first response is held.
    bp_mode = 2;
    issue(1'b0, 2'd2, 1'b0, BASE + 32'd20, 32'd0, "stall_a");
    req_addr = BASE + 32'd24;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    bp_mode = 0;
    @(posedge clock);
    #1;
    issue(1'b0, 2'd2, 1'b0, BASE + 32'd24, 32'd0, "stall_b");
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      issue(1'b0, 2'($urandom_range(0, 2)), 1'($urandom), BASE + 32'(i * 4), 32'd0, "burst");
    chk("burst_cycles", cyc - t0, 32'd8);
    drain("burst");

    bp_mode = 1;
    for (int i = 0; i < 150; i++)
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            BASE + 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3)), $urandom, "rand");
    drain("rand");

    // Reset with a response pending; the store driven during reset must not land.
    bp_mode = 2;
    issue(1'b0, 2'd2, 1'b0, BASE, 32'd0, "pre_reset");
    chk("pre_reset_valid", 32'(resp_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(resp_valid), 32'd0);
    chk("async_rst_rdata", resp_rdata, 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    sbq.delete();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd2;
    req_addr  = BASE;
    req_wdata = 32'hBAD0_BAD0;
    repeat (2) @(posedge clock);
    #1;
    req_valid = 1'b0;
    reset_n   = 1'b1;
    bp_mode   = 0;
    @(posedge clock);
    #1;
    issue(1'b0, 2'd2, 1'b0, BASE, 32'd0, "post_reset_retain");
    issue(1'b0, 2'd2, 1'b0, BASE + 32'd4, 32'd0, "post_reset_next");
    drain("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
